// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared types and index-width helper for the stream mux
package stream_mux_pkg;
  typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mode_e;
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotating-priority one-hot arbiter that owns the round-robin pointer
module rr_arbiter import stream_mux_pkg::*; #(
  parameter int N_IN = 4,
  parameter int SW = idx_w(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] req,
  input  logic            advance,
  input  logic [SW-1:0]   adv_idx,
  output logic [N_IN-1:0] grant
);
  logic [SW-1:0] ptr;
  logic [SW:0] pos;
  logic hit;
  // first requester found walking ptr, ptr+1, ... with wrap at N_IN
  always_comb begin
    grant = '0;
    hit = 1'b0;
    pos = '0;
    for (int k = 0; k < N_IN; k++) begin
      pos = {1'b0, ptr} + (SW+1)'(k);
      pos = (pos >= (SW+1)'(N_IN)) ? pos - (SW+1)'(N_IN) : pos;
      if (!hit && req[pos[SW-1:0]]) begin
        grant[pos[SW-1:0]] = 1'b1;
        hit = 1'b1;
      end
    end
  end
  // pointer moves just past the channel that was served
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (advance) ptr <= (adv_idx == SW'(N_IN - 1)) ? '0 : adv_idx + 1'b1;
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N:1 valid/ready stream mux, fixed or round-robin select, registered output
module stream_mux_rr import stream_mux_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int N_IN = 4,
  parameter int SW = idx_w(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rr_en,
  input  logic [SW-1:0]         sel,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SW-1:0]         out_src,
  output logic                  out_valid,
  input  logic                  out_ready
);
  logic [WIDTH-1:0] chan [N_IN];
  logic [N_IN-1:0] rr_grant, fix_grant, grant;
  logic [SW-1:0] gidx;
  logic [WIDTH-1:0] gdata;
  logic load_en, xfer;
  mode_e mode;
  genvar i;
  generate
    for (i = 0; i < N_IN; i++) begin : g_unpack
      assign chan[i] = in_data[i*WIDTH +: WIDTH];
    end
  endgenerate
  assign mode = rr_en ? MODE_RR : MODE_FIXED;
  // fixed mode: only the selected channel can win; an out-of-range sel matches nothing
  always_comb begin
    fix_grant = '0;
    for (int k = 0; k < N_IN; k++) fix_grant[k] = (sel == SW'(k)) & in_valid[k];
  end
  rr_arbiter #(.N_IN(N_IN), .SW(SW)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(in_valid),
    .advance(xfer & (mode == MODE_RR)),
    .adv_idx(gidx),
    .grant(rr_grant)
  );
  assign grant = (mode == MODE_RR) ? rr_grant : fix_grant;
  assign load_en = !out_valid | out_ready;
  assign in_ready = grant & {N_IN{load_en & !rst}};
  assign xfer = |in_ready;
  // one-hot grant to index, and the winning channel's word
  always_comb begin
    gidx = '0;
    gdata = '0;
    for (int k = 0; k < N_IN; k++)
      if (grant[k]) begin
        gidx = SW'(k);
        gdata = chan[k];
      end
  end
  // output register: load on input transfer, empty on drain, hold on stall
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_src <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data <= gdata;
      out_src <= gidx;
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed and randomized checks of stream_mux_rr against a behavioural model
module tb_stream_mux_rr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rr_en = 1'b1;
  logic [1:0] sel = '0;
  logic [3:0] ch [4];
  logic [15:0] in_data;
  logic [3:0] in_valid = 4'hF;
  logic [3:0] in_ready;
  logic [3:0] out_data;
  logic [1:0] out_src;
  logic out_valid;
  logic out_ready = 1'b1;
  logic rr3 = 1'b0;
  logic [1:0] sel3 = 2'd3;
  logic [23:0] d3 = 24'h33_22_11;
  logic [2:0] v3 = 3'b000;
  logic [2:0] ready3;
  logic [7:0] od3;
  logic [1:0] os3;
  logic ov3;
  logic or3 = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  bit m_valid;
  logic [3:0] m_data;
  logic [1:0] m_src;
  int m_ptr;

  always #5 clk = ~clk;
  assign in_data = {ch[3], ch[2], ch[1], ch[0]};

  stream_mux_rr #(.WIDTH(4), .N_IN(4)) dut (
    .clk(clk), .rst(rst), .rr_en(rr_en), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(8), .N_IN(3)) dut3 (
    .clk(clk), .rst(rst), .rr_en(rr3), .sel(sel3), .in_data(d3),
    .in_valid(v3), .in_ready(ready3), .out_data(od3),
    .out_src(os3), .out_valid(ov3), .out_ready(or3)
  );

  function automatic int m_grant();
    if (rst || (m_valid && !out_ready)) return -1;
    if (!rr_en) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 0; k < 4; k++)
      if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] m_ready();
    int g;
    g = m_grant();
    return (g < 0) ? 4'b0000 : 4'(1 << g);
  endfunction

  task automatic tick();
    int g;
    g = m_grant();
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_data = '0;
      m_src = '0;
      m_ptr = 0;
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_data = ch[g];
      m_src = 2'(g);
      if (rr_en) m_ptr = (g + 1) % 4;
    end else if (out_ready) m_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 4'hF;
    #1;
    n_vec++;
    if (in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", in_ready); end
    tick();
    n_vec++;
    if ({out_valid, out_data, out_src} !== 7'd0) begin
      n_err++; $display("FAIL reset_out: got v=%b d=%h s=%0d want all 0", out_valid, out_data, out_src);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 4'b0001) begin n_err++; $display("FAIL reset_ptr: got %b want 0001", in_ready); end
    tick();
    n_vec++;
    if (out_src !== 2'd0 || out_valid !== 1'b1) begin n_err++; $display("FAIL reset_first: got s=%0d v=%b want s=0 v=1", out_src, out_valid); end
  endtask

  task automatic test_fixed();
    rr_en = 1'b0;
    sel = 2'd2;
    ch[0] = 4'h5; ch[1] = 4'h3; ch[2] = 4'hA; ch[3] = 4'hC;
    in_valid = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if (in_ready !== 4'b0100 || in_ready !== m_ready()) begin n_err++; $display("FAIL fixed_ready: got %b want 0100", in_ready); end
      tick();
      n_vec++;
      if ({out_valid, out_src, out_data} !== {1'b1, 2'd2, 4'hA}) begin
        n_err++; $display("FAIL fixed_out: got v=%b s=%0d d=%h want v=1 s=2 d=a", out_valid, out_src, out_data);
      end
    end
    sel = 2'd3;
    in_valid = 4'b0111;
    #1;
    n_vec++;
    if (in_ready !== 4'b0000) begin n_err++; $display("FAIL fixed_nogrant: got %b want 0000", in_ready); end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL fixed_drop: got v=%b want 0", out_valid); end
  endtask

  task automatic test_rr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rr_en = 1'b1;
    ch[0] = 4'h1; ch[1] = 4'h2; ch[2] = 4'h3; ch[3] = 4'h4;
    in_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_vec++;
      if (in_ready !== 4'(1 << (i % 4))) begin n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", i, in_ready, 4'(1 << (i % 4))); end
      tick();
      n_vec++;
      if ({out_valid, out_src, out_data} !== {1'b1, 2'(i % 4), 4'(i % 4 + 1)}) begin
        n_err++; $display("FAIL rr_out[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d d=%0d", i, out_valid, out_src, out_data, i % 4, i % 4 + 1);
      end
    end
  endtask

  task automatic test_skip();
    in_valid = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++;
      if (out_src !== ((i % 2) ? 2'd3 : 2'd1) || out_valid !== 1'b1) begin
        n_err++; $display("FAIL skip_alt[%0d]: got s=%0d v=%b want s=%0d v=1", i, out_src, out_valid, (i % 2) ? 3 : 1);
      end
    end
    in_valid = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({out_valid, out_src, out_data} !== {1'b1, 2'd3, 4'h4}) begin
        n_err++; $display("FAIL skip_only3[%0d]: got v=%b s=%0d d=%h want v=1 s=3 d=4", i, out_valid, out_src, out_data);
      end
    end
  endtask

  task automatic test_backpressure();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ch[0] = 4'h7; ch[1] = 4'h8; ch[2] = 4'h9; ch[3] = 4'hA;
    in_valid = 4'hF;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (in_ready !== 4'b0000) begin n_err++; $display("FAIL stall_ready[%0d]: got %b want 0000", i, in_ready); end
      tick();
      n_vec++;
      if ({out_valid, out_src, out_data} !== {1'b1, 2'd0, 4'h7}) begin
        n_err++; $display("FAIL stall_hold[%0d]: got v=%b s=%0d d=%h want v=1 s=0 d=7", i, out_valid, out_src, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 4'b0010) begin n_err++; $display("FAIL stall_release_ready: got %b want 0010", in_ready); end
    tick();
    n_vec++;
    if ({out_valid, out_src, out_data} !== {1'b1, 2'd1, 4'h8}) begin
      n_err++; $display("FAIL stall_nobubble: got v=%b s=%0d d=%h want v=1 s=1 d=8", out_valid, out_src, out_data);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 4'b0000) begin n_err++; $display("FAIL midrst_ready: got %b want 0000", in_ready); end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 4'b0001) begin n_err++; $display("FAIL midrst_ptr: got %b want 0001", in_ready); end
    tick();
  endtask

  task automatic test_nonpow2();
    sel3 = 2'd3;
    v3 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if (ready3 !== 3'b000) begin n_err++; $display("FAIL np2_ready[%0d]: got %b want 000", i, ready3); end
      tick();
      n_vec++;
      if (ov3 !== 1'b0) begin n_err++; $display("FAIL np2_valid[%0d]: got %b want 0", i, ov3); end
    end
    for (int s = 1; s < 3; s++) begin
      sel3 = 2'(s);
      #1;
      n_vec++;
      if (ready3 !== 3'(1 << s)) begin n_err++; $display("FAIL np2_sel_ready[%0d]: got %b want %b", s, ready3, 3'(1 << s)); end
      tick();
      n_vec++;
      if ({ov3, os3, od3} !== {1'b1, 2'(s), 8'(8'h11 * (s + 1))}) begin
        n_err++; $display("FAIL np2_sel_out[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d d=%h", s, ov3, os3, od3, s, 8'h11 * (s + 1));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      rr_en = ($urandom_range(0, 3) != 0);
      sel = 2'($urandom_range(0, 3));
      in_valid = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) ch[k] = 4'($urandom);
      #1;
      n_vec++;
      if (in_ready !== m_ready()) begin n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, m_ready()); end
      tick();
      n_vec++;
      if (out_valid !== m_valid || (m_valid && {out_src, out_data} !== {m_src, m_data})) begin
        n_err++; $display("FAIL rand_out[%0d]: got v=%b s=%0d d=%h want v=%b s=%0d d=%h", i, out_valid, out_src, out_data, m_valid, m_src, m_data);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) ch[k] = 4'(k + 1);
    m_valid = 1'b0;
    m_data = '0;
    m_src = '0;
    m_ptr = 0;
    test_reset();
    test_fixed();
    test_rr();
    test_skip();
    test_backpressure();
    test_reset_mid();
    test_nonpow2();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
